// File: rtl/axi_regfile_pkg.sv
// Shared types and helpers for the axi_regfile_v2 register file.
//   resp_t      : AXI response codes used on BRESP/RRESP
//   wr_state_t  : write-channel FSM states
//   rd_state_t  : read-channel FSM states
//   strb_merge  : byte-lane merge of write data into an existing word
package axi_regfile_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_HAVE_AW = 2'd1,
    W_HAVE_W  = 2'd2,
    W_RESP    = 2'd3
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Replace each byte of old_val whose strobe bit is set with the matching byte of data.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] data,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_regfile_wr_chan.sv
// Write channel of axi_regfile_v2: AW/W acceptance FSM with skid latches so the
// address and data phases may arrive in either order, plus the B response.
// Ports:
//   i_clk, i_srst            clock, synchronous active-high reset
//   i_awaddr/i_awvalid/o_awready   AW channel
//   i_wdata/i_wstrb/i_wvalid/o_wready  W channel
//   o_bresp/o_bvalid/i_bready  B channel
//   o_commit                 1 in the cycle both halves of a write are present;
//                            the register array updates on the following edge
//   o_idx/o_data/o_strb      register index, data and byte strobes of that write
module axi_regfile_wr_chan
  import axi_regfile_pkg::*;
#(
  parameter int NREGS      = 16,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  i_clk,
  input  logic                  i_srst,
  input  logic [ADDR_WIDTH-1:0] i_awaddr,
  input  logic                  i_awvalid,
  output logic                  o_awready,
  input  logic [31:0]           i_wdata,
  input  logic [3:0]            i_wstrb,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  output logic [1:0]            o_bresp,
  output logic                  o_bvalid,
  input  logic                  i_bready,
  output logic                  o_commit,
  output logic [ADDR_WIDTH-3:0] o_idx,
  output logic [31:0]           o_data,
  output logic [3:0]            o_strb
);

  localparam int IDXW = ADDR_WIDTH - 2;

  wr_state_t        r_state;
  logic [IDXW-1:0]  r_idx;
  logic [31:0]      r_data;
  logic [3:0]       r_strb;
  logic             r_bvalid;
  resp_t            r_bresp;

  logic             w_aw_hs;
  logic             w_w_hs;
  logic             w_in_range;
  logic             w_unused;

  // Byte offset within a word carries no meaning for a word-wide register file.
  assign w_unused = ^i_awaddr[1:0];

  // Ready is gated by reset so that both are low while reset is held and
  // high in the very first cycle after it is released.
  assign o_awready = ((r_state == W_IDLE) || (r_state == W_HAVE_W))  && !i_srst;
  assign o_wready  = ((r_state == W_IDLE) || (r_state == W_HAVE_AW)) && !i_srst;

  assign w_aw_hs = i_awvalid && o_awready;
  assign w_w_hs  = i_wvalid  && o_wready;

  assign o_commit = ((r_state == W_IDLE)    && w_aw_hs && w_w_hs) ||
                    ((r_state == W_HAVE_AW) && w_w_hs) ||
                    ((r_state == W_HAVE_W)  && w_aw_hs);

  // Whichever half arrived first comes from the latch, the other from the bus.
  assign o_idx  = (r_state == W_HAVE_AW) ? r_idx  : i_awaddr[ADDR_WIDTH-1:2];
  assign o_data = (r_state == W_HAVE_W)  ? r_data : i_wdata;
  assign o_strb = (r_state == W_HAVE_W)  ? r_strb : i_wstrb;

  assign w_in_range = {1'b0, o_idx} < (IDXW+1)'(NREGS);

  assign o_bvalid = r_bvalid;
  assign o_bresp  = r_bresp;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_state  <= W_IDLE;
      r_idx    <= '0;
      r_data   <= '0;
      r_strb   <= '0;
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else begin
      case (r_state)
        W_IDLE: begin
          if (w_aw_hs && !w_w_hs) begin
            r_idx   <= i_awaddr[ADDR_WIDTH-1:2];
            r_state <= W_HAVE_AW;
          end else if (w_w_hs && !w_aw_hs) begin
            r_data  <= i_wdata;
            r_strb  <= i_wstrb;
            r_state <= W_HAVE_W;
          end
        end
        W_RESP: begin
          if (i_bready) begin
            r_bvalid <= 1'b0;
            r_state  <= W_IDLE;
          end
        end
        default: ;
      endcase
      if (o_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_in_range ? RESP_OKAY : RESP_SLVERR;
        r_state  <= W_RESP;
      end
    end
  end

endmodule

// File: rtl/axi_regfile_v2.sv
// AXI4-Lite slave register file with NREGS 32-bit registers.
// Each register is RW, RO (writes ignored, OKAY) or PULSE (written value shows
// for one cycle then clears). Readback comes from slv_read so the fabric picks
// the value returned for each register.
// Ports:
//   S_AXI_ACLK / S_AXI_ARESET   clock, synchronous active-high reset
//   S_AXI_AW*, W*, B*, AR*, R*  AXI4-Lite slave (PROT inputs ignored)
//   slv_reg      register contents to fabric
//   slv_read     readback value per register
//   slv_wr_stb   per-register pulse in the cycle slv_reg[i] takes a write
//   slv_rd_stb   per-register pulse in the cycle a read of it is accepted
//   err_count    number of SLVERR responses issued, saturating
// Build option: define AXI_REGFILE_ERRCNT_EN to build the SLVERR counter;
// without it err_count is constant zero.
module axi_regfile_v2
  import axi_regfile_pkg::*;
#(
  parameter int                         NREGS      = 16,
  parameter int                         ADDR_WIDTH = 6,
  parameter logic [NREGS-1:0]           RO_MASK    = '0,
  parameter logic [NREGS-1:0]           PULSE_MASK = '0,
  parameter logic [NREGS-1:0][31:0]     RESET_VAL  = '0
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESET,
  input  logic [ADDR_WIDTH-1:0]         S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [31:0]                   S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]         S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [31:0]                   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [NREGS-1:0][31:0]        slv_reg,
  input  logic [NREGS-1:0][31:0]        slv_read,
  output logic [NREGS-1:0]              slv_wr_stb,
  output logic [NREGS-1:0]              slv_rd_stb,
  output logic [15:0]                   err_count
);

  localparam int IDXW = ADDR_WIDTH - 2;

  if ((NREGS < 2) || (NREGS > 256)) begin : g_bad_nregs
    $error("axi_regfile_v2: NREGS must be in 2..256");
  end
  if (ADDR_WIDTH < $clog2(NREGS) + 2) begin : g_bad_addr_width
    $error("axi_regfile_v2: ADDR_WIDTH too small for NREGS");
  end

  // ---------------- write channel ----------------
  logic             w_commit;
  logic [IDXW-1:0]  w_idx;
  logic [31:0]      w_data;
  logic [3:0]       w_strb;

  axi_regfile_wr_chan #(
    .NREGS      (NREGS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wr_chan (
    .i_clk     (S_AXI_ACLK),
    .i_srst    (S_AXI_ARESET),
    .i_awaddr  (S_AXI_AWADDR),
    .i_awvalid (S_AXI_AWVALID),
    .o_awready (S_AXI_AWREADY),
    .i_wdata   (S_AXI_WDATA),
    .i_wstrb   (S_AXI_WSTRB),
    .i_wvalid  (S_AXI_WVALID),
    .o_wready  (S_AXI_WREADY),
    .o_bresp   (S_AXI_BRESP),
    .o_bvalid  (S_AXI_BVALID),
    .i_bready  (S_AXI_BREADY),
    .o_commit  (w_commit),
    .o_idx     (w_idx),
    .o_data    (w_data),
    .o_strb    (w_strb)
  );

  // ---------------- register array ----------------
  logic [31:0] r_regs   [NREGS];
  logic        r_wr_stb [NREGS];

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    logic w_hit;
    // Out-of-range indices never match any gi, and RO registers never take a hit.
    assign w_hit = w_commit && (w_idx == IDXW'(gi)) && !RO_MASK[gi];

    always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
        r_regs[gi]   <= RESET_VAL[gi];
        r_wr_stb[gi] <= 1'b0;
      end else begin
        r_wr_stb[gi] <= w_hit;
        if (PULSE_MASK[gi]) begin
          // Pulse registers only hold the current write, merged onto zero.
          r_regs[gi] <= w_hit ? strb_merge(32'h0, w_data, w_strb) : 32'h0;
        end else if (w_hit) begin
          r_regs[gi] <= strb_merge(r_regs[gi], w_data, w_strb);
        end
      end
    end

    assign slv_reg[gi]    = r_regs[gi];
    assign slv_wr_stb[gi] = r_wr_stb[gi];
  end

  // ---------------- read channel ----------------
  rd_state_t        r_rd_state;
  logic [31:0]      r_rdata;
  resp_t            r_rresp;
  logic             r_rvalid;

  logic             w_ar_hs;
  logic [IDXW-1:0]  w_ar_idx;
  logic             w_ar_in_range;
  logic [31:0]      w_rd_word;
  logic             w_unused;

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0]};

  assign S_AXI_ARREADY = (r_rd_state == R_IDLE) && !S_AXI_ARESET;
  assign w_ar_hs       = S_AXI_ARVALID && S_AXI_ARREADY;
  assign w_ar_idx      = S_AXI_ARADDR[ADDR_WIDTH-1:2];
  assign w_ar_in_range = {1'b0, w_ar_idx} < (IDXW+1)'(NREGS);

  // Select by compare so an out-of-range index simply yields zero.
  always_comb begin
    w_rd_word = 32'h0;
    for (int k = 0; k < NREGS; k++) begin
      if (w_ar_idx == IDXW'(k)) w_rd_word = slv_read[k];
    end
  end

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_rd_stb
    assign slv_rd_stb[gi] = w_ar_hs && (w_ar_idx == IDXW'(gi));
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_rd_state <= R_IDLE;
      r_rdata    <= 32'h0;
      r_rresp    <= RESP_OKAY;
      r_rvalid   <= 1'b0;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rdata    <= w_rd_word;
            r_rresp    <= w_ar_in_range ? RESP_OKAY : RESP_SLVERR;
            r_rvalid   <= 1'b1;
            r_rd_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            r_rvalid   <= 1'b0;
            r_rd_state <= R_IDLE;
          end
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  assign S_AXI_RDATA  = r_rdata;
  assign S_AXI_RRESP  = r_rresp;
  assign S_AXI_RVALID = r_rvalid;

  // ---------------- SLVERR counter ----------------
`ifdef AXI_REGFILE_ERRCNT_EN
  logic [15:0] r_err_count;
  logic        w_wr_slverr;
  logic        w_rd_slverr;
  logic [1:0]  w_err_inc;
  logic [16:0] w_err_sum;

  // A response is counted on the edge that issues it (commit / AR accept).
  assign w_wr_slverr = w_commit && ({1'b0, w_idx} >= (IDXW+1)'(NREGS));
  assign w_rd_slverr = w_ar_hs && !w_ar_in_range;
  assign w_err_inc   = {1'b0, w_wr_slverr} + {1'b0, w_rd_slverr};
  assign w_err_sum   = {1'b0, r_err_count} + {15'b0, w_err_inc};

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_err_count <= 16'h0;
    end else if (w_err_sum[16]) begin
      r_err_count <= 16'hFFFF;
    end else begin
      r_err_count <= w_err_sum[15:0];
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = 16'h0;
`endif

endmodule

// File: tb/tb_axi_regfile_v2.sv
module tb_axi_regfile_v2;

  localparam int NREGS = 16;
  localparam int AW    = 8;

`ifdef AXI_REGFILE_ERRCNT_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  function automatic logic [NREGS-1:0][31:0] mk_reset_val();
    logic [NREGS-1:0][31:0] rv;
    rv    = '0;
    rv[3] = 32'h0000_1234;
    rv[6] = 32'h0000_0066;
    return rv;
  endfunction

  localparam logic [NREGS-1:0][31:0] TB_RESET_VAL = mk_reset_val();
  localparam logic [NREGS-1:0]       TB_RO_MASK    = 16'h0040;
  localparam logic [NREGS-1:0]       TB_PULSE_MASK = 16'h0020;

  logic                    clk;
  logic                    srst;
  logic [AW-1:0]           awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [31:0]             wdata;
  logic [3:0]              wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [AW-1:0]           araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [31:0]             rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;
  logic [NREGS-1:0][31:0]  slv_reg;
  logic [NREGS-1:0][31:0]  slv_read;
  logic [NREGS-1:0]        slv_wr_stb;
  logic [NREGS-1:0]        slv_rd_stb;
  logic [15:0]             err_count;

  // Fabric loops register contents straight back as readback.
  assign slv_read = slv_reg;

  axi_regfile_v2 #(
    .NREGS      (NREGS),
    .ADDR_WIDTH (AW),
    .RO_MASK    (TB_RO_MASK),
    .PULSE_MASK (TB_PULSE_MASK),
    .RESET_VAL  (TB_RESET_VAL)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (srst),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .slv_reg       (slv_reg),
    .slv_read      (slv_read),
    .slv_wr_stb    (slv_wr_stb),
    .slv_rd_stb    (slv_rd_stb),
    .err_count     (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Running event counters, sampled mid-cycle; tests compare before/after deltas.
  int wr_stb_cnt [NREGS];
  int rd_stb_cnt [NREGS];
  int b_hs_cnt;
  int pulse5_cycles;
  bit [31:0] pulse5_val;

  initial begin
    b_hs_cnt      = 0;
    pulse5_cycles = 0;
    pulse5_val    = 32'h0;
    for (int i = 0; i < NREGS; i++) begin
      wr_stb_cnt[i] = 0;
      rd_stb_cnt[i] = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (slv_wr_stb[i]) wr_stb_cnt[i] <= wr_stb_cnt[i] + 1;
      if (slv_rd_stb[i]) rd_stb_cnt[i] <= rd_stb_cnt[i] + 1;
    end
    if (bvalid && bready) b_hs_cnt <= b_hs_cnt + 1;
    if (!srst && slv_reg[5] != 32'h0) begin
      pulse5_cycles <= pulse5_cycles + 1;
      pulse5_val    <= slv_reg[5];
    end
  end

  int n_checks;
  int n_errors;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] resp);
    logic aw_done, w_done, hs_aw, hs_w;
    aw_done = 1'b0;
    w_done  = 1'b0;
    resp    = 2'b11;
    awaddr  = a;
    wdata   = d;
    wstrb   = s;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    bready  = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      tick();
      if (hs_aw) begin aw_done = 1'b1; awvalid = 1'b0; end
      if (hs_w)  begin w_done  = 1'b1; wvalid  = 1'b0; end
      if (aw_done && w_done) break;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check_val("wr_accept", {31'b0, aw_done && w_done}, 32'd1);
    @(negedge clk);
    check_val("wr_latency", {31'b0, bvalid}, 32'd1);
    resp = bresp;
    tick();
    bready = 1'b0;
    $display("WR addr=%h data=%h strb=%b resp=%b", a, d, s, resp);
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp);
    logic ar_done, hs_ar;
    ar_done = 1'b0;
    d       = 32'hDEAD_BEEF;
    resp    = 2'b11;
    araddr  = a;
    arvalid = 1'b1;
    rready  = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      hs_ar = arvalid && arready;
      tick();
      if (hs_ar) begin ar_done = 1'b1; break; end
    end
    arvalid = 1'b0;
    check_val("rd_accept", {31'b0, ar_done}, 32'd1);
    @(negedge clk);
    check_val("rd_latency", {31'b0, rvalid}, 32'd1);
    d    = rdata;
    resp = rresp;
    tick();
    rready = 1'b0;
    $display("RD addr=%h data=%h resp=%b", a, d, resp);
  endtask

  // BVALID must stay up for 5 cycles of BREADY low, then complete exactly once.
  task automatic b_hold_check(input string tag);
    int hold;
    int b0;
    hold = 0;
    b0   = b_hs_cnt;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bvalid) hold++;
      tick();
    end
    check_val({tag, "_hold"}, 32'(hold), 32'd5);
    bready = 1'b1;
    @(negedge clk);
    check_val({tag, "_bvalid"}, {31'b0, bvalid}, 32'd1);
    check_val({tag, "_bresp"}, {30'b0, bresp}, 32'd0);
    tick();
    bready = 1'b0;
    @(negedge clk);
    check_val({tag, "_bdone"}, {31'b0, bvalid}, 32'd0);
    check_val({tag, "_bcount"}, 32'(b_hs_cnt - b0), 32'd1);
    tick();
    $display("WR %s completed after BREADY hold", tag);
  endtask

  logic [31:0] rd;
  logic [1:0]  rsp;
  int          snap;
  int          snap2;

  initial begin
    n_checks = 0;
    n_errors = 0;
    srst = 1'b1;
    awaddr = '0; awprot = 3'b0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = 3'b0; arvalid = 1'b0; rready = 1'b0;

    // ---- 1: reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_awready", {31'b0, awready}, 32'd0);
    check_val("rst_wready",  {31'b0, wready},  32'd0);
    check_val("rst_arready", {31'b0, arready}, 32'd0);
    tick();
    srst = 1'b0;
    @(negedge clk);
    check_val("post_rst_awready", {31'b0, awready}, 32'd1);
    check_val("post_rst_arready", {31'b0, arready}, 32'd1);
    check_val("post_rst_bvalid",  {31'b0, bvalid},  32'd0);
    check_val("post_rst_rvalid",  {31'b0, rvalid},  32'd0);
    check_val("post_rst_rdata",   rdata,            32'h0);
    check_val("post_rst_errcnt",  {16'b0, err_count}, 32'h0);
    check_val("post_rst_reg3",    slv_reg[3],       32'h0000_1234);
    check_val("post_rst_wrstb",   {16'b0, slv_wr_stb}, 32'h0);
    tick();
    snap = rd_stb_cnt[3];
    do_read(8'h0C, rd, rsp);
    check_val("t1_rdata", rd, 32'h0000_1234);
    check_val("t1_rresp", {30'b0, rsp}, 32'd0);
    check_val("t1_rd_stb", 32'(rd_stb_cnt[3] - snap), 32'd1);

    // ---- 2: byte strobes ----
    snap = wr_stb_cnt[2];
    do_write(8'h08, 32'hAABB_CCDD, 4'b0101, rsp);
    check_val("t2_bresp", {30'b0, rsp}, 32'd0);
    check_val("t2_reg2", slv_reg[2], 32'h00BB_00DD);
    check_val("t2_wr_stb", 32'(wr_stb_cnt[2] - snap), 32'd1);

    // ---- 3: AW ahead of W, then W ahead of AW, BREADY held low ----
    awaddr = 8'h1C; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    @(negedge clk);
    check_val("t3a_awready_low", {31'b0, awready}, 32'd0);
    check_val("t3a_wready_high", {31'b0, wready},  32'd1);
    tick();
    tick();
    wdata = 32'h1111_2222; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check_val("t3a_reg7", slv_reg[7], 32'h1111_2222);
    b_hold_check("t3a");

    wdata = 32'h3333_4444; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    @(negedge clk);
    check_val("t3b_wready_low", {31'b0, wready},  32'd0);
    check_val("t3b_awready_high", {31'b0, awready}, 32'd1);
    tick();
    tick();
    awaddr = 8'h20; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check_val("t3b_reg8", slv_reg[8], 32'h3333_4444);
    b_hold_check("t3b");

    // ---- 4: out-of-range access ----
    do_read(8'h40, rd, rsp);
    check_val("t4_rresp", {30'b0, rsp}, 32'h2);
    check_val("t4_rdata", rd, 32'h0);
    check_val("t4_errcnt_rd", {16'b0, err_count}, 32'(ERR_EN));
    do_write(8'h44, 32'hFFFF_FFFF, 4'hF, rsp);
    check_val("t4_bresp", {30'b0, rsp}, 32'h2);
    check_val("t4_errcnt_wr", {16'b0, err_count}, 32'(2 * ERR_EN));

    // ---- 5: pulse, read-only and zero-strobe writes ----
    snap  = pulse5_cycles;
    snap2 = wr_stb_cnt[5];
    do_write(8'h14, 32'h0000_0001, 4'hF, rsp);
    check_val("t5_pulse_cycles", 32'(pulse5_cycles - snap), 32'd1);
    check_val("t5_pulse_val", pulse5_val, 32'h1);
    check_val("t5_pulse_cleared", slv_reg[5], 32'h0);
    check_val("t5_pulse_stb", 32'(wr_stb_cnt[5] - snap2), 32'd1);

    snap = wr_stb_cnt[6];
    do_write(8'h18, 32'hFFFF_FFFF, 4'hF, rsp);
    check_val("t5_ro_bresp", {30'b0, rsp}, 32'd0);
    check_val("t5_ro_reg6", slv_reg[6], 32'h0000_0066);
    check_val("t5_ro_stb", 32'(wr_stb_cnt[6] - snap), 32'd0);

    snap = wr_stb_cnt[2];
    do_write(8'h08, 32'h1234_5678, 4'b0000, rsp);
    check_val("t5_zstrb_bresp", {30'b0, rsp}, 32'd0);
    check_val("t5_zstrb_reg2", slv_reg[2], 32'h00BB_00DD);
    check_val("t5_zstrb_stb", 32'(wr_stb_cnt[2] - snap), 32'd1);

    // ---- 6: simultaneous read and write of reg 4, then reset with B pending ----
    do_write(8'h10, 32'h0000_0007, 4'hF, rsp);
    araddr = 8'h10; arvalid = 1'b1; rready = 1'b0;
    awaddr = 8'h10; awvalid = 1'b1;
    wdata = 32'h0000_0009; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check_val("t6_rvalid", {31'b0, rvalid}, 32'd1);
    check_val("t6_rdata_old", rdata, 32'h0000_0007);
    check_val("t6_bvalid", {31'b0, bvalid}, 32'd1);
    check_val("t6_reg4_new", slv_reg[4], 32'h0000_0009);
    $display("RW same-cycle reg4 rdata=%h reg4=%h", rdata, slv_reg[4]);
    tick();
    snap = b_hs_cnt;
    srst = 1'b1;
    tick();
    @(negedge clk);
    check_val("t6_rst_bvalid", {31'b0, bvalid}, 32'd0);
    check_val("t6_rst_rvalid", {31'b0, rvalid}, 32'd0);
    check_val("t6_rst_reg4", slv_reg[4], 32'h0);
    check_val("t6_rst_reg3", slv_reg[3], 32'h0000_1234);
    check_val("t6_rst_reg2", slv_reg[2], 32'h0);
    tick();
    srst = 1'b0;
    bready = 1'b1;
    repeat (3) tick();
    bready = 1'b0;
    check_val("t6_no_b_after_rst", 32'(b_hs_cnt - snap), 32'd0);
    $display("RST mid-transaction: B abandoned");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard cap in case a handshake never resolves.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
